// File: rtl/ac_zone_controller.sv
// ----------------------------------------------------------------------------
// ac_zone_controller
//
// Multi-zone air-conditioner controller. Each zone holds a setpoint that the
// up/down buttons adjust, and an "actual" temperature that steps one unit per
// track tick toward that setpoint. Operation is held off by a post-reset
// warm-up. A sticky condensate (drip) alarm is raised after sustained cooling.
// Everything runs in the clk_2 domain. The tick input acts as a clock enable.
//
// Ports
//   clk_2     in   sole clock, rising edge
//   reset     in   asynchronous, active-high; clears all state
//   tick      in   one-cycle enable; state advances only when high
//   up        in   level; raise the selected zone's setpoint
//   down      in   level; lower the selected zone's setpoint
//   zone_sel  in   zone addressed by up/down
//   drip_clr  in   level; clears drip alarm and counter, independent of tick
//   setpoint  out  packed setpoints, zone z at [z*TEMP_BITS +: TEMP_BITS]
//   actual    out  packed actual temperatures, same packing
//   heating   out  bit z: actual_z < setpoint_z
//   cooling   out  bit z: actual_z > setpoint_z
//   ready     out  0 during warm-up, 1 afterwards
//   drip      out  sticky condensate alarm
// ----------------------------------------------------------------------------
module ac_zone_controller #(
  parameter int TEMP_BITS    = 3,
  parameter int NZONES       = 2,
  parameter int WARMUP_TICKS = 10,
  parameter int DRIP_TICKS   = 6,
  localparam int ZSEL_BITS   = (NZONES > 1) ? $clog2(NZONES) : 1
) (
  input  logic                        clk_2,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        up,
  input  logic                        down,
  input  logic [ZSEL_BITS-1:0]        zone_sel,
  input  logic                        drip_clr,
  output logic [NZONES*TEMP_BITS-1:0] setpoint,
  output logic [NZONES*TEMP_BITS-1:0] actual,
  output logic [NZONES-1:0]           heating,
  output logic [NZONES-1:0]           cooling,
  output logic                        ready,
  output logic                        drip
);

  localparam int WCNT_BITS = (WARMUP_TICKS > 1) ? $clog2(WARMUP_TICKS) : 1;
  localparam int DCNT_BITS = $clog2(DRIP_TICKS + 1);

  localparam logic [WCNT_BITS-1:0] WARM_LAST = WCNT_BITS'(WARMUP_TICKS - 1);
  localparam logic [DCNT_BITS-1:0] DRIP_MAX  = DCNT_BITS'(DRIP_TICKS);
  localparam logic [TEMP_BITS-1:0] TEMP_MAX  = '1;
  localparam logic [TEMP_BITS-1:0] TEMP_ONE  = TEMP_BITS'(1);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_ADJUST = 2'd1,
    ST_TRACK  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WCNT_BITS-1:0] warm_q, warm_d;
  logic [DCNT_BITS-1:0] drip_cnt_q, drip_cnt_d, drip_inc;
  logic                 drip_q, drip_d;
  logic [TEMP_BITS-1:0] sp_q  [NZONES];
  logic [TEMP_BITS-1:0] sp_d  [NZONES];
  logic [TEMP_BITS-1:0] act_q [NZONES];
  logic [TEMP_BITS-1:0] act_d [NZONES];
  logic                 any_cooling;

  // --------------------------------------------------------------------------
  // Outputs and per-zone comparison flags, straight from the registers.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    setpoint = '0;
    actual   = '0;
    heating  = '0;
    cooling  = '0;
    for (int z = 0; z < NZONES; z++) begin
      setpoint[z*TEMP_BITS +: TEMP_BITS] = sp_q[z];
      actual[z*TEMP_BITS +: TEMP_BITS]   = act_q[z];
      heating[z] = (act_q[z] < sp_q[z]);
      cooling[z] = (act_q[z] > sp_q[z]);
    end
  end

  assign any_cooling = |cooling;
  assign ready       = (state_q != ST_WARMUP);
  assign drip        = drip_q;
  assign drip_inc    = drip_cnt_q + DCNT_BITS'(1);

  // --------------------------------------------------------------------------
  // Next-state and next-datapath logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    drip_cnt_d = drip_cnt_q;
    drip_d     = drip_q;
    sp_d       = sp_q;
    act_d      = act_q;

    if (tick) begin
      case (state_q)
        ST_WARMUP: begin
          // Buttons are ignored. The count holds once warm-up completes
          // because it is never read again.
          if (warm_q == WARM_LAST) begin
            state_d = ST_ADJUST;
          end else begin
            warm_d = warm_q + WCNT_BITS'(1);
          end
        end

        ST_ADJUST: begin
          if (!up && !down) begin
            state_d = ST_TRACK;
          end else begin
            // Matching against each zone index means an out-of-range
            // zone_sel selects nothing, rather than indexing past the array.
            for (int z = 0; z < NZONES; z++) begin
              if (zone_sel == ZSEL_BITS'(z)) begin
                if (up && !down && sp_q[z] != TEMP_MAX) begin
                  sp_d[z] = sp_q[z] + TEMP_ONE;
                end else if (down && !up && sp_q[z] != '0) begin
                  sp_d[z] = sp_q[z] - TEMP_ONE;
                end
              end
            end
          end
        end

        ST_TRACK: begin
          state_d = ST_ADJUST;
          for (int z = 0; z < NZONES; z++) begin
            if (act_q[z] < sp_q[z]) begin
              act_d[z] = act_q[z] + TEMP_ONE;
            end else if (act_q[z] > sp_q[z]) begin
              act_d[z] = act_q[z] - TEMP_ONE;
            end
          end
          // Drip uses the cooling flags from before this tick's step.
          if (any_cooling) begin
            if (drip_cnt_q != DRIP_MAX) begin
              drip_cnt_d = drip_inc;
              if (drip_inc == DRIP_MAX) begin
                drip_d = 1'b1;
              end
            end
          end else begin
            drip_cnt_d = '0;
          end
        end

        default: state_d = ST_WARMUP;
      endcase
    end

    // The clear wins over any set or increment on the same edge.
    if (drip_clr) begin
      drip_cnt_d = '0;
      drip_d     = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_2 or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, whatever the statement order.
    if (reset) begin
      state_q <= ST_WARMUP;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      warm_q     <= '0;
      drip_cnt_q <= '0;
      drip_q     <= 1'b0;
      // NOTE: the per-zone arrays are a handful of flops rather than a RAM,
      // so each element is reset explicitly. An unreset array would leave
      // setpoint/actual undefined after reset.
      for (int z = 0; z < NZONES; z++) begin
        sp_q[z]  <= '0;
        act_q[z] <= '0;
      end
    end else begin
      warm_q     <= warm_d;
      drip_cnt_q <= drip_cnt_d;
      drip_q     <= drip_d;
      for (int z = 0; z < NZONES; z++) begin
        sp_q[z]  <= sp_d[z];
        act_q[z] <= act_d[z];
      end
    end
  end

endmodule

// File: tb/tb_ac_zone_controller.sv
// ----------------------------------------------------------------------------
// tb_ac_zone_controller
//
// Directed bench for ac_zone_controller using default parameters
// (TEMP_BITS=3, NZONES=2, WARMUP_TICKS=10, DRIP_TICKS=6). The bench computes
// expected values itself, from hand-derived formulas per tick. Zone 1 sits in
// bits [5:3] of setpoint/actual, and zone 0 in bits [2:0].
// ----------------------------------------------------------------------------
module tb_ac_zone_controller;

  logic       clk_2;
  logic       reset;
  logic       tick;
  logic       up;
  logic       down;
  logic [0:0] zone_sel;
  logic       drip_clr;
  logic [5:0] setpoint;
  logic [5:0] actual;
  logic [1:0] heating;
  logic [1:0] cooling;
  logic       ready;
  logic       drip;

  int vectors     = 0;
  int miscompares = 0;

  ac_zone_controller dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .tick     (tick),
    .up       (up),
    .down     (down),
    .zone_sel (zone_sel),
    .drip_clr (drip_clr),
    .setpoint (setpoint),
    .actual   (actual),
    .heating  (heating),
    .cooling  (cooling),
    .ready    (ready),
    .drip     (drip)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle: set the inputs at the falling edge, then return 1 time
  // unit after the rising edge with tick and drip_clr dropped. The button
  // levels stay as driven.
  task automatic step(input logic t, input logic u, input logic d,
                      input logic c, input logic zs);
    @(negedge clk_2);
    tick = t; up = u; down = d; drip_clr = c; zone_sel = zs;
    @(posedge clk_2);
    #1;
    tick = 1'b0; drip_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; up = 1'b0; down = 1'b0;
    drip_clr = 1'b0; zone_sel = 1'b0;
    #2;
    check("rst_setpoint", 32'(setpoint), 0);
    check("rst_actual",   32'(actual),   0);
    check("rst_heating",  32'(heating),  0);
    check("rst_cooling",  32'(cooling),  0);
    check("rst_ready",    32'(ready),    0);
    check("rst_drip",     32'(drip),     0);

    // Warm-up with up held; the buttons must be ignored.
    @(negedge clk_2);
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step(1, 1, 0, 0, 1);
      check("warm_ready_low", 32'(ready), 0);
      check("warm_sp_zero",   32'(setpoint), 0);
    end
    step(1, 1, 0, 0, 1);
    check("warm_ready_high", 32'(ready), 1);
    check("warm_sp_after",   32'(setpoint), 0);

    // Adjust zone 1 upward and check saturation at 7.
    for (int k = 1; k <= 9; k++) begin
      step(1, 1, 0, 0, 1);
      check("adj_up_sp", 32'(setpoint), ((k > 7) ? 7 : k) << 3);
    end
    step(0, 1, 0, 0, 1);
    check("notick_hold_sp", 32'(setpoint), 7 << 3);
    check("adj_heating",    32'(heating), 2'b10);
    step(1, 1, 1, 0, 1);
    step(1, 1, 1, 0, 1);
    check("both_btn_sp",     32'(setpoint), 7 << 3);
    check("both_btn_actual", 32'(actual), 0);

    // Tracking: ADJUST and TRACK alternate, so actual steps every other tick.
    for (int i = 1; i <= 14; i++) begin
      step(1, 0, 0, 0, 1);
      check("trk_actual",  32'(actual), (i / 2) << 3);
      check("trk_heating", 32'(heating), ((i / 2) < 7) ? 2 : 0);
    end
    check("trk_cooling", 32'(cooling), 0);

    // Lower setpoint_1 to 0, then release and cool down to set the alarm.
    for (int k = 1; k <= 7; k++) begin
      step(1, 0, 1, 0, 1);
      check("adj_down_sp", 32'(setpoint), (7 - k) << 3);
    end
    check("cool_flag", 32'(cooling), 2'b10);
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0, 0, 1);
      check("cool_actual", 32'(actual), (7 - (((i / 2) > 7) ? 7 : (i / 2))) << 3);
      check("cool_drip",   32'(drip), (i >= 12) ? 1 : 0);
    end
    check("cool_done_flag", 32'(cooling), 0);
    step(0, 0, 0, 1, 1);
    check("drip_clr_notick", 32'(drip), 0);

    // Clear priority, on zone 0: bring actual_0 to 6, then cool to 0.
    for (int k = 1; k <= 6; k++) step(1, 1, 0, 0, 0);
    check("prio_sp_up", 32'(setpoint), 6);
    for (int i = 1; i <= 12; i++) step(1, 0, 0, 0, 0);
    check("prio_actual_up", 32'(actual), 6);
    for (int k = 1; k <= 6; k++) step(1, 0, 1, 0, 0);
    check("prio_sp_down", 32'(setpoint), 0);
    check("prio_cooling", 32'(cooling), 2'b01);
    for (int i = 1; i <= 11; i++) step(1, 0, 0, 0, 0);
    check("prio_pre_drip",   32'(drip), 0);
    check("prio_pre_actual", 32'(actual), 1);
    step(1, 0, 0, 1, 0);
    check("prio_clr_drip",   32'(drip), 0);
    check("prio_clr_actual", 32'(actual), 0);

    // Reset mid-operation, in TRACK with actual_1 = 3.
    for (int k = 1; k <= 5; k++) step(1, 1, 0, 0, 1);
    check("mid_sp", 32'(setpoint), 5 << 3);
    for (int i = 1; i <= 7; i++) step(1, 0, 0, 0, 1);
    check("mid_actual", 32'(actual), 3 << 3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_setpoint", 32'(setpoint), 0);
    check("mid_rst_actual",   32'(actual),   0);
    check("mid_rst_heating",  32'(heating),  0);
    check("mid_rst_ready",    32'(ready),    0);
    check("mid_rst_drip",     32'(drip),     0);
    @(negedge clk_2);
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step(1, 1, 0, 0, 1);
      check("rewarm_ready_low", 32'(ready), 0);
    end
    step(1, 1, 0, 0, 1);
    check("rewarm_ready_high", 32'(ready), 1);
    check("rewarm_sp_zero",    32'(setpoint), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
